// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode bundle for fetch_buffer: two in-order slots each way plus occupancy.
// master = fetch/decode side, slave = the buffer itself.
interface fetch_buffer_if #(
   parameter int DEPTH       = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
);
   logic [1:0]                  in_valid;
   logic [1:0][INSTR_WIDTH-1:0] in_instr;
   logic [1:0][ADDR_WIDTH-1:0]  in_pc;
   logic [1:0]                  in_guesses_branch;
   logic [1:0][ADDR_WIDTH-1:0]  in_prediction;
   logic                        in_ready;
   logic [1:0]                  out_valid;
   logic [1:0][INSTR_WIDTH-1:0] out_instr;
   logic [1:0][ADDR_WIDTH-1:0]  out_pc;
   logic [1:0]                  out_guesses_branch;
   logic [1:0][ADDR_WIDTH-1:0]  out_prediction;
   logic                        out_ready;
   logic [$clog2(DEPTH):0]      count;

   modport master (
      output in_valid, in_instr, in_pc, in_guesses_branch, in_prediction, out_ready,
      input  in_ready, out_valid, out_instr, out_pc, out_guesses_branch, out_prediction, count
   );

   modport slave (
      input  in_valid, in_instr, in_pc, in_guesses_branch, in_prediction, out_ready,
      output in_ready, out_valid, out_instr, out_pc, out_guesses_branch, out_prediction, count
   );
endinterface

// File: rtl/fetch_buffer.sv
// 2-wide in-order instruction queue between fetch and decode, flushed on redirect.
// Optional FETCH_BUF_BYPASS_EN: zero-latency pass-through of fetch slots while empty.
module fetch_buffer #(
   parameter int DEPTH       = 8,
   parameter int ADDR_WIDTH  = 32,
   parameter int INSTR_WIDTH = 32
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          flush,
   fetch_buffer_if.slave fb
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;
   localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h00000013);

   logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];
   logic [ADDR_WIDTH-1:0]  pc_mem    [DEPTH];
   logic [ADDR_WIDTH-1:0]  pred_mem  [DEPTH];
   logic [DEPTH-1:0]       gb_mem;

   logic [PTR_W-1:0] head, tail, count_q;
   logic [IDX_W-1:0] wr_idx0, wr_idx1, rd_idx0, rd_idx1;
   logic [1:0]       legal_valid, wr_en, buf_valid;
   logic [1:0]       n_enq, n_deq;
   logic             in_ready, bypass;

   function automatic logic [1:0] popcount2(input logic [1:0] v);
      return {1'b0, v[0]} + {1'b0, v[1]};
   endfunction

   // slot1 without slot0 is malformed fetch output and is ignored entirely
   assign legal_valid = (fb.in_valid == 2'b11) ? 2'b11 :
                        (fb.in_valid == 2'b01) ? 2'b01 : 2'b00;

   // two entries stay reserved so a full pair can always be absorbed
   assign in_ready  = (count_q <= PTR_W'(DEPTH - 2));
   assign buf_valid = {count_q >= PTR_W'(2), count_q >= PTR_W'(1)};

`ifdef FETCH_BUF_BYPASS_EN
   assign bypass = (count_q == '0) && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign wr_en = (in_ready && !(bypass && fb.out_ready)) ? legal_valid : 2'b00;
   assign n_enq = popcount2(wr_en);
   assign n_deq = (fb.out_ready && !bypass) ? popcount2(buf_valid) : 2'b00;

   assign wr_idx0 = tail[IDX_W-1:0];
   assign wr_idx1 = wr_idx0 + IDX_W'(1);
   assign rd_idx0 = head[IDX_W-1:0];
   assign rd_idx1 = rd_idx0 + IDX_W'(1);

   assign fb.in_ready = in_ready;
   assign fb.count    = count_q;

   always_comb begin
      fb.out_valid          = bypass ? legal_valid : buf_valid;
      fb.out_instr          = {NOP, NOP};
      fb.out_pc             = '0;
      fb.out_guesses_branch = '0;
      fb.out_prediction     = '0;
      if (bypass) begin
         for (int i = 0; i < 2; i++) begin
            if (legal_valid[i]) begin
               fb.out_instr[i]          = fb.in_instr[i];
               fb.out_pc[i]             = fb.in_pc[i];
               fb.out_guesses_branch[i] = fb.in_guesses_branch[i];
               fb.out_prediction[i]     = fb.in_prediction[i];
            end
         end
      end else begin
         if (buf_valid[0]) begin
            fb.out_instr[0]          = instr_mem[rd_idx0];
            fb.out_pc[0]             = pc_mem[rd_idx0];
            fb.out_guesses_branch[0] = gb_mem[rd_idx0];
            fb.out_prediction[0]     = pred_mem[rd_idx0];
         end
         if (buf_valid[1]) begin
            fb.out_instr[1]          = instr_mem[rd_idx1];
            fb.out_pc[1]             = pc_mem[rd_idx1];
            fb.out_guesses_branch[1] = gb_mem[rd_idx1];
            fb.out_prediction[1]     = pred_mem[rd_idx1];
         end
      end
   end

   // control state: pointers carry a wrap bit, so count is kept explicitly
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else if (flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         head    <= head + PTR_W'(n_deq);
         tail    <= tail + PTR_W'(n_enq);
         count_q <= count_q + PTR_W'(n_enq) - PTR_W'(n_deq);
      end
   end

   // storage is never reset; validity comes solely from count_q
   always_ff @(posedge clk) begin
      if (wr_en[0]) begin
         instr_mem[wr_idx0] <= fb.in_instr[0];
         pc_mem[wr_idx0]    <= fb.in_pc[0];
         gb_mem[wr_idx0]    <= fb.in_guesses_branch[0];
         pred_mem[wr_idx0]  <= fb.in_prediction[0];
      end
      if (wr_en[1]) begin
         instr_mem[wr_idx1] <= fb.in_instr[1];
         pc_mem[wr_idx1]    <= fb.in_pc[1];
         gb_mem[wr_idx1]    <= fb.in_guesses_branch[1];
         pred_mem[wr_idx1]  <= fb.in_prediction[1];
      end
   end
endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: an ordered queue of accepted instructions is the model;
// the monitor compares each cycle's decode-side view against the head of that queue.
module tb_fetch_buffer;
   localparam int DEPTH = 8;
   localparam int AW    = 32;
   localparam int IW    = 32;
   localparam logic [31:0] NOP = 32'h00000013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        gb;
      logic [31:0] pred;
   } ent_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic flush = 1'b0;

   fetch_buffer_if #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) fb_if ();

   fetch_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .fb      (fb_if)
   );

   always #5 clk = ~clk;

   ent_t        sbq[$];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cur_pre = 0;
   int          cur_nacc = 0;
   logic        cur_flush = 1'b0;
   logic        mon_en = 1'b0;
   logic [31:0] next_pc = 32'h0000_1000;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ent_t out_ent(input int i);
      ent_t e;
      e.instr = fb_if.out_instr[i];
      e.pc    = fb_if.out_pc[i];
      e.gb    = fb_if.out_guesses_branch[i];
      e.pred  = fb_if.out_prediction[i];
      return e;
   endfunction

   task automatic check_reset(input string tag);
      chk({tag, "_count"},     128'(fb_if.count), 128'(0));
      chk({tag, "_out_valid"}, 128'(fb_if.out_valid), 128'(2'b00));
      chk({tag, "_in_ready"},  128'(fb_if.in_ready), 128'(1'b1));
      chk({tag, "_slot0"},     128'(out_ent(0)), 128'(ent_t'({NOP, 65'h0})));
      chk({tag, "_slot1"},     128'(out_ent(1)), 128'(ent_t'({NOP, 65'h0})));
   endtask

   // one cycle of stimulus; accepted entries go into the scoreboard queue
   task automatic drive(input logic [1:0] v, input logic rdy, input logic fl, input logic [31:0] pc0);
      int   nacc;
      ent_t e;
      @(negedge clk);
      fb_if.in_valid = v;
      for (int i = 0; i < 2; i++) begin
         fb_if.in_instr[i]          = $urandom;
         fb_if.in_pc[i]             = pc0 + 32'(4 * i);
         fb_if.in_guesses_branch[i] = 1'($urandom);
         fb_if.in_prediction[i]     = $urandom;
      end
      fb_if.out_ready = rdy;
      flush  = fl;
      mon_en = 1'b1;
      #2;
      cur_pre = sbq.size();
      nacc = (cur_pre <= DEPTH - 2) ? ((v == 2'b11) ? 2 : (v == 2'b01) ? 1 : 0) : 0;
      cur_nacc  = nacc;
      cur_flush = fl;
      if (!fl) begin
         for (int i = 0; i < nacc; i++) begin
            e.instr = fb_if.in_instr[i];
            e.pc    = fb_if.in_pc[i];
            e.gb    = fb_if.in_guesses_branch[i];
            e.pred  = fb_if.in_prediction[i];
            sbq.push_back(e);
         end
      end
   endtask

   task automatic drv(input logic [1:0] v, input logic rdy, input logic fl);
      drive(v, rdy, fl, next_pc);
      next_pc += 32'h8;
   endtask

   task automatic rnd(input int n, input int ready_pct, input int flush_pct);
      logic [1:0] v;
      int r;
      for (int k = 0; k < n; k++) begin
         r = $urandom_range(0, 9);
         v = (r < 2) ? 2'b00 : (r == 2) ? 2'b10 : (r < 6) ? 2'b01 : 2'b11;
         drv(v, ($urandom_range(0, 99) < ready_pct), ($urandom_range(0, 99) < flush_pct));
      end
   endtask

   // monitor: compares the decode-side view against the model each cycle
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (mon_en && reset_n) begin
            int   nv;
            ent_t e;
            nv = (cur_pre >= 2) ? 2 : cur_pre;
`ifdef FETCH_BUF_BYPASS_EN
            if (cur_pre == 0 && !cur_flush) nv = cur_nacc;
`endif
            chk("count", 128'(fb_if.count), 128'(cur_pre));
            chk("in_ready", 128'(fb_if.in_ready), 128'(cur_pre <= DEPTH - 2));
            chk("out_valid", 128'(fb_if.out_valid),
                128'((nv == 2) ? 2'b11 : (nv == 1) ? 2'b01 : 2'b00));
            for (int i = 0; i < 2; i++) begin
               e = (i < nv) ? sbq[i] : ent_t'({NOP, 65'h0});
               chk((i == 0) ? "slot0" : "slot1", 128'(out_ent(i)), 128'(e));
            end
            if (cur_flush) sbq.delete();
            else if (fb_if.out_ready) repeat (nv) void'(sbq.pop_front());
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      fb_if.in_valid          = 2'b00;
      fb_if.in_instr          = '0;
      fb_if.in_pc             = '0;
      fb_if.in_guesses_branch = '0;
      fb_if.in_prediction     = '0;
      fb_if.out_ready         = 1'b0;
      repeat (2) @(negedge clk);
      check_reset("init");
      reset_n = 1'b1;

      // pair with decode ready, pcs 0x100/0x104
      drive(2'b11, 1'b1, 1'b0, 32'h100);
      drv(2'b00, 1'b1, 1'b0);
      drv(2'b00, 1'b1, 1'b0);

      // fill with decode stalled, then drain in order
      repeat (8) drv(2'b11, 1'b0, 1'b0);
      repeat (6) drv(2'b00, 1'b1, 1'b0);

      // steady state with count 3, then random traffic across the wrap
      drv(2'b11, 1'b0, 1'b0);
      drv(2'b01, 1'b0, 1'b0);
      drv(2'b11, 1'b1, 1'b0);
      rnd(20, 70, 0);
      repeat (5) drv(2'b00, 1'b1, 1'b0);

      // flush with five entries and a pair arriving
      drv(2'b11, 1'b0, 1'b0);
      drv(2'b11, 1'b0, 1'b0);
      drv(2'b01, 1'b0, 1'b0);
      drv(2'b11, 1'b0, 1'b1);
      drv(2'b00, 1'b0, 1'b0);

      // malformed slot1-only valid versus single slot0
      drv(2'b10, 1'b0, 1'b0);
      drv(2'b01, 1'b0, 1'b0);
      drv(2'b10, 1'b1, 1'b0);
      drv(2'b00, 1'b1, 1'b0);

      rnd(300, 60, 3);

      // asynchronous reset in the middle of traffic
      repeat (4) drv(2'b11, 1'b0, 1'b0);
      @(negedge clk);
      mon_en = 1'b0;
      flush = 1'b0;
      fb_if.in_valid = 2'b00;
      #1 reset_n = 1'b0;
      #1 check_reset("midrst");
      sbq.delete();
      @(negedge clk);
      reset_n = 1'b1;

      rnd(50, 60, 3);
      repeat (6) drv(2'b00, 1'b1, 1'b0);
      @(negedge clk);
      #5;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
